noc_input_buffer: RTL and testbench



---
 rtl/noc_input_buffer.sv | 62 ++++++
 tb/tb_noc_input_buffer.sv | 107 ++++++++++
 2 files changed

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port NoC input FIFO with credit return; optional same-cycle bypass via NOC_INBUF_BYPASS_EN
module noc_input_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     credit_o,
    output logic                     flit_valid_o,
    output logic [DATA_W-1:0]        flit_o,
    input  logic                     flit_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic credit_q, credit_d, overflow_q, overflow_d;
    logic byp, full, deq, enq, wr, rd;
`ifdef NOC_INBUF_BYPASS_EN
    assign byp = (count_q == '0) && valid_i;
`else
    assign byp = 1'b0;
`endif
    // handshake, bypass steering and next-state for pointers, count, credit and overflow
    always_comb begin
        full         = count_q == CW'(DEPTH);
        flit_valid_o = (count_q != '0) || byp;
        flit_o       = byp ? data_i : mem_q[rd_ptr_q];
        deq          = flit_valid_o && flit_ready_i;
        enq          = valid_i && (!full || deq);
        wr           = enq && !(byp && flit_ready_i);
        rd           = deq && !byp;
        wr_ptr_d     = wr_ptr_q + PW'(wr);
        rd_ptr_d     = rd_ptr_q + PW'(rd);
        count_d      = count_q + CW'(wr) - CW'(rd);
        credit_d     = deq;
        overflow_d   = overflow_q || (valid_i && !enq);
        mem_d        = mem_q;
        if (wr) mem_d[wr_ptr_q] = data_i;
    end
    // control state; reset discards stored flits and any pending credit
    always_ff @(posedge clk) begin
        rd_ptr_q   <= rst ? '0 : rd_ptr_d;
        wr_ptr_q   <= rst ? '0 : wr_ptr_d;
        count_q    <= rst ? '0 : count_d;
        credit_q   <= rst ? 1'b0 : credit_d;
        overflow_q <= rst ? 1'b0 : overflow_d;
    end
    // flit storage needs no reset: it is only read while count is nonzero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
    assign credit_o   = credit_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer: directed + random stimulus against a queue scoreboard for noc_input_buffer
module tb_noc_input_buffer;
    logic        clk = 0;
    logic        rst, valid_i, flit_ready_i;
    logic [15:0] data_i;
    logic        credit_o, flit_valid_o, overflow_o;
    logic [15:0] flit_o;
    logic [2:0]  count_o;
    int tests = 0, fails = 0;
    logic [15:0] q[$];
    bit exp_credit, exp_ovf, chk_en;
`ifdef NOC_INBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    noc_input_buffer #(.DATA_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
        .credit_o(credit_o), .flit_valid_o(flit_valid_o), .flit_o(flit_o),
        .flit_ready_i(flit_ready_i), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [15:0] d, input bit rdy, input string tag);
        bit byp, fv, deq, enq;
        @(negedge clk);
        rst = r; valid_i = v; data_i = d; flit_ready_i = rdy;
        #1;
        byp = BYP && q.size() == 0 && v;
        fv  = q.size() != 0 || byp;
        deq = fv && rdy;
        enq = v && (q.size() < 4 || deq);
        if (chk_en) begin
            chk({tag, ".valid"}, 32'(flit_valid_o), 32'(fv));
            if (fv) chk({tag, ".flit"}, 32'(flit_o), byp ? 32'(d) : 32'(q[0]));
            chk({tag, ".count"}, 32'(count_o), 32'(q.size()));
            chk({tag, ".credit"}, 32'(credit_o), 32'(exp_credit));
            chk({tag, ".ovf"}, 32'(overflow_o), 32'(exp_ovf));
        end
        @(posedge clk);
        if (r) begin
            q.delete(); exp_credit = 0; exp_ovf = 0;
        end else begin
            if (deq && !byp) void'(q.pop_front());
            if (enq && !(byp && rdy)) q.push_back(d);
            exp_credit = deq;
            if (v && !enq) exp_ovf = 1;
        end
    endtask

    initial begin
        rst = 1; valid_i = 0; data_i = 0; flit_ready_i = 0; chk_en = 0;
        step(1, 0, 0, 0, "rst0");
        chk_en = 1;
        step(1, 0, 0, 0, "rst1");
        step(0, 0, 0, 0, "reset_state");
        // single flit
        step(0, 1, 16'hA5A5, 0, "t1_wr");
        step(0, 0, 0, 0, "t1_hold");
        step(0, 0, 0, 1, "t1_deq");
        step(0, 0, 0, 0, "t1_credit");
        step(0, 0, 0, 0, "t1_nocredit");
        // fill and order
        for (int i = 1; i <= 4; i++) step(0, 1, 16'(i), 0, "t2_fill");
        step(0, 0, 0, 0, "t2_full");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "t2_drain");
        step(0, 0, 0, 0, "t2_end");
        step(0, 0, 0, 0, "t2_idle");
        // full with simultaneous enq/deq
        for (int i = 1; i <= 4; i++) step(0, 1, 16'(i), 0, "t3_fill");
        step(0, 1, 16'h0005, 1, "t3_simul");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "t3_drain");
        step(0, 0, 0, 0, "t3_end");
        // overflow
        for (int i = 0; i < 4; i++) step(0, 1, 16'h0010 + 16'(i), 0, "t4_fill");
        step(0, 1, 16'hDEAD, 0, "t4_ovf");
        step(0, 0, 0, 0, "t4_sticky");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "t4_drain");
        step(0, 0, 0, 0, "t4_after");
        step(1, 0, 0, 0, "t4_rst");
        step(0, 0, 0, 0, "t4_cleared");
        // reset mid-stream with a deq in the reset cycle
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0020 + 16'(i), 0, "t5_fill");
        step(1, 0, 0, 1, "t5_rst_deq");
        step(0, 0, 0, 0, "t5_after");
        // bypass / minimum latency
        step(0, 1, 16'h1234, 1, "t6_in");
        step(0, 0, 0, 1, "t6_next");
        step(0, 0, 0, 0, "t6_end");
        // random mix
        for (int i = 0; i < 60; i++)
            step(i == 30, 1'($urandom), 16'($urandom), 1'($urandom), "rand");
        step(0, 0, 0, 0, "final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
